// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: mem_op field
// positions, funct3 encodings, the FSM state type and small helpers for
// access size, byte enables and store lane placement.
package dmem_pkg;

  // mem_op field positions
  localparam int OP_VALID = 4;
  localparam int OP_STORE = 3;
  localparam int OP_F3_HI = 2;
  localparam int OP_F3_LO = 0;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Access size, taken from funct3[1:0]; the unused code 2'b11 behaves as a word
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // A halfword must sit on an even address, a word on a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = offset[0];
      default: mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

  // Byte enables for an aligned access of the given size at the given offset.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << offset;
      SZ_HALF: be = 4'b0011 << offset;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across the word so every enabled lane carries it.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      SZ_BYTE: lanes = {4{data[7:0]}};
      SZ_HALF: lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the access controller (master) and the memory (slave).
//
// Handshake: the master raises dmem_req together with stable dmem_we, dmem_addr,
// dmem_be and dmem_wdata and holds all of them unchanged until the cycle in
// which the slave raises dmem_gnt; the request is accepted at that clock edge
// and dmem_req drops afterwards. For a read, the slave later raises dmem_rvalid
// for exactly one cycle with dmem_rdata valid, no earlier than the cycle after
// the grant. Writes get no response. gnt/rvalid outside an outstanding request
// are ignored by the master.
interface dmem_access_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/dmem_load_fmt.sv
// Load data formatter: selects the addressed byte or halfword of the read word
// and sign- or zero-extends it according to funct3. Purely combinational.
module dmem_load_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ext;

  // Lane select and extension; funct3[2] marks the unsigned variants
  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    sign_ext = ~funct3[2];
    data     = rdata;
    case (funct3[1:0])
      SZ_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the M1 stage. Accepts one load or store
// at a time, runs it over the req/gnt/rvalid bus, stalls the pipeline while
// it is outstanding and returns formatted load data for writeback.
// Optional feature macro: DMEM_TIMEOUT_EN adds a gnt/rvalid timeout that
// ends the access with a one-cycle bus_err pulse.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [4:0]                mem_op,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  input  logic                      flush,
  output logic                      stall,
  output logic                      misalign,
  output logic [31:0]               load_data,
  output logic                      load_valid,
  output logic                      bus_err,
  dmem_access_ctrl_if.master        dmem,
  output state_t                    dbg_state
);

  state_t      state;
  logic        we_q;
  logic [29:0] addr_q;
  logic [1:0]  off_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic        kill_q;
  logic        req_q;
  logic [31:0] load_data_q;
  logic        load_valid_q;
  logic        bus_err_q;

  logic [1:0]  op_size;
  logic        op_misaligned;
  logic        accept;
  logic [31:0] fmt_data;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expired;
  assign wait_expired = (wait_cnt == CNT_LAST);
`endif

  // Decode of the M1 op; only meaningful while the FSM sits in IDLE
  always_comb begin
    op_size       = mem_op[OP_F3_LO +: 2];
    op_misaligned = is_misaligned(op_size, addr[1:0]);
    accept        = nrst & (state == ST_IDLE) & mem_op[OP_VALID] & ~flush & ~op_misaligned;
    misalign      = (state == ST_IDLE) & mem_op[OP_VALID] & op_misaligned;
    // The accept cycle stalls combinationally so M1 holds the op into REQ
    stall         = accept | (state == ST_REQ) | (state == ST_RESP);
  end

  dmem_load_fmt u_load_fmt (
    .rdata  (dmem.dmem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (fmt_data)
  );

  // Access sequencer: IDLE -> REQ -> (RESP for loads) -> DONE -> IDLE
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= ST_IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      off_q        <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      f3_q         <= '0;
      kill_q       <= 1'b0;
      req_q        <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_REQ;
            we_q    <= mem_op[OP_STORE];
            addr_q  <= addr[31:2];
            off_q   <= addr[1:0];
            be_q    <= byte_en(op_size, addr[1:0]);
            wdata_q <= lane_data(op_size, wdata);
            f3_q    <= mem_op[OP_F3_HI:OP_F3_LO];
            kill_q  <= 1'b0;
            req_q   <= 1'b1;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (flush) kill_q <= 1'b1;
          if (dmem.dmem_gnt) begin
            req_q <= 1'b0;
            state <= we_q ? ST_DONE : ST_RESP;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
`ifdef DMEM_TIMEOUT_EN
          else if (wait_expired) begin
            req_q     <= 1'b0;
            bus_err_q <= 1'b1;
            state     <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (flush) kill_q <= 1'b1;
          if (dmem.dmem_rvalid) begin
            load_data_q  <= fmt_data;
            // A flush arriving with rvalid still kills the writeback
            load_valid_q <= ~(kill_q | flush);
            state        <= ST_DONE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (wait_expired) begin
            bus_err_q <= 1'b1;
            state     <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus and result outputs come straight from registers
  always_comb begin
    dmem.dmem_req   = req_q;
    dmem.dmem_we    = we_q;
    dmem.dmem_addr  = {addr_q, 2'b00};
    dmem.dmem_be    = be_q;
    dmem.dmem_wdata = wdata_q;
    load_data       = load_data_q;
    load_valid      = load_valid_q;
`ifdef DMEM_TIMEOUT_EN
    bus_err         = bus_err_q;
`else
    bus_err         = 1'b0;
`endif
    dbg_state       = state;
  end

`ifndef DMEM_TIMEOUT_EN
  // Without the timeout the error flag stays at its reset value; keep it tied off
  logic unused_bus_err;
  assign unused_bus_err = bus_err_q;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl. Directed operations drive the M1
// side and act as the memory; a compare process checks every bus request and
// every load result against a size/offset model of the access rules.
// Build with DMEM_TIMEOUT_EN defined to also exercise the timeout path.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

`ifdef DMEM_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic        clk;
  logic        nrst;
  logic [4:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        stall;
  logic        misalign;
  logic [31:0] load_data;
  logic        load_valid;
  logic        bus_err;
  state_t      dbg_state;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .mem_op     (mem_op),
    .addr       (addr),
    .wdata      (wdata),
    .flush      (flush),
    .stall      (stall),
    .misalign   (misalign),
    .load_data  (load_data),
    .load_valid (load_valid),
    .bus_err    (bus_err),
    .dmem       (bus),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];
  logic        exp_req_valid = 1'b0;
  logic [31:0] exp_addr;
  logic [3:0]  exp_be;
  logic        exp_we;
  logic [31:0] exp_wdata;
  logic        exp_bus_err = 1'b0;
  logic [3:0]  seen_be;
  logic [31:0] seen_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
    int n;
    n = size_bytes(f3);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (be[k]) m = m | (32'hFF << (8 * k));
    return m;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] v;
    v = rd >> (8 * off);
    case (f3)
      3'b000: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
      3'b001: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
      3'b100: v = v & 32'hFF;
      3'b101: v = v & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    #2;
    if (nrst) begin
      if (!exp_req_valid) begin
        check("stray_req", {31'd0, bus.dmem_req}, 32'd0);
      end else if (bus.dmem_req) begin
        check("req_addr", bus.dmem_addr, exp_addr);
        check("req_be", {28'd0, bus.dmem_be}, {28'd0, exp_be});
        check("req_we", {31'd0, bus.dmem_we}, {31'd0, exp_we});
        if (exp_we)
          check("req_wdata", bus.dmem_wdata & lane_mask(exp_be), exp_wdata & lane_mask(exp_be));
        seen_be    = bus.dmem_be;
        seen_wdata = bus.dmem_wdata;
      end
      if (load_valid) begin
        check("load_valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("load_data", load_data, exp_q.pop_front());
      end
      check("bus_err", {31'd0, bus_err}, {31'd0, exp_bus_err});
    end
  end

  // ---------------- driver tasks ----------------
  // flush_at: 0 none, 1 first REQ cycle, 2 first RESP cycle
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int gnt_dly, input int rv_dly, input int flush_at);
    logic lv_exp;
    lv_exp = !st && (flush_at == 0);
    @(negedge clk);
    mem_op = {1'b1, st, f3};
    addr = a;
    wdata = wd;
    flush = 1'b0;
    exp_addr = {a[31:2], 2'b00};
    exp_be = model_be(f3, a[1:0]);
    exp_we = st;
    exp_wdata = wd << (8 * a[1:0]);
    exp_req_valid = 1'b1;
    #1;
    check("accept_stall", {31'd0, stall}, 32'd1);
    check("accept_misalign", {31'd0, misalign}, 32'd0);
    for (int i = 0; i <= gnt_dly; i++) begin
      @(negedge clk);
      bus.dmem_gnt = (i == gnt_dly);
      flush = (flush_at == 1) && (i == 0);
      #1;
      check("req_state", {30'd0, dbg_state}, {30'd0, ST_REQ});
      check("req_held", {31'd0, bus.dmem_req}, 32'd1);
      check("req_stall", {31'd0, stall}, 32'd1);
    end
    if (!st) begin
      for (int j = 1; j <= rv_dly; j++) begin
        @(negedge clk);
        bus.dmem_gnt = 1'b0;
        flush = (flush_at == 2) && (j == 1);
        bus.dmem_rvalid = (j == rv_dly);
        bus.dmem_rdata = (j == rv_dly) ? rd : $urandom;
        #1;
        check("resp_state", {30'd0, dbg_state}, {30'd0, ST_RESP});
        check("resp_stall", {31'd0, stall}, 32'd1);
        check("resp_req_low", {31'd0, bus.dmem_req}, 32'd0);
      end
      if (lv_exp) exp_q.push_back(model_load(rd, a[1:0], f3));
    end
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata = $urandom;
    flush = 1'b0;
    #1;
    check("done_state", {30'd0, dbg_state}, {30'd0, ST_DONE});
    check("done_stall", {31'd0, stall}, 32'd0);
    check("done_load_valid", {31'd0, load_valid}, {31'd0, lv_exp});
    @(posedge clk);
    #1;
    mem_op = 5'd0;
    exp_req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("back_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
  endtask

  // An op that must be refused in IDLE (misaligned or flushed)
  task automatic refused_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic fl, input logic mis_exp);
    @(negedge clk);
    mem_op = {1'b1, st, f3};
    addr = a;
    flush = fl;
    #1;
    check("refuse_misalign", {31'd0, misalign}, {31'd0, mis_exp});
    check("refuse_stall", {31'd0, stall}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("refuse_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    end
    mem_op = 5'd0;
    flush = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nrst = 1'b0;
    mem_op = 5'd0;
    addr = '0;
    wdata = '0;
    flush = 1'b0;
    bus.dmem_gnt = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_load_valid", {31'd0, load_valid}, 32'd0);
    check("rst_be", {28'd0, bus.dmem_be}, 32'd0);
    nrst = 1'b1;

    // SW: be 1111, addr 0x100, 3-cycle access
    run_op(1'b1, F3_SW, 32'h100, 32'hDEADBEEF, '0, 0, 0, 0);
    check("sw_be_lit", {28'd0, seen_be}, 32'h0000000F);
    check("sw_wdata_lit", seen_wdata, 32'hDEADBEEF);

    // SB to the top byte lane
    run_op(1'b1, F3_SB, 32'h103, 32'h000000A5, '0, 1, 0, 0);
    check("sb_be_lit", {28'd0, seen_be}, 32'h00000008);
    check("sb_lane_lit", {24'd0, seen_wdata[31:24]}, 32'h000000A5);

    // SH to the upper half
    run_op(1'b1, F3_SH, 32'h102, 32'h00001234, '0, 0, 0, 0);
    check("sh_be_lit", {28'd0, seen_be}, 32'h0000000C);

    // LB / LBU with delayed gnt and rvalid
    run_op(1'b0, F3_LB, 32'h202, '0, 32'h00800000, 2, 3, 0);
    check("lb_data_lit", load_data, 32'hFFFFFF80);
    run_op(1'b0, F3_LBU, 32'h202, '0, 32'h00800000, 2, 3, 0);
    check("lbu_data_lit", load_data, 32'h00000080);

    // A store leaves the last load result untouched
    run_op(1'b1, F3_SW, 32'h104, 32'h0BADF00D, '0, 0, 0, 0);
    check("load_data_hold", load_data, 32'h00000080);

    // Halfword and word loads, back-to-back gnt/rvalid
    run_op(1'b0, F3_LH, 32'h302, '0, 32'h80011234, 0, 1, 0);
    check("lh_data_lit", load_data, 32'hFFFF8001);
    run_op(1'b0, F3_LHU, 32'h302, '0, 32'h80011234, 0, 1, 0);
    check("lhu_data_lit", load_data, 32'h00008001);
    run_op(1'b0, F3_LW, 32'h308, '0, 32'hCAFEF00D, 1, 2, 0);
    check("lw_data_lit", load_data, 32'hCAFEF00D);
    run_op(1'b0, F3_LB, 32'h301, '0, 32'h00007F00, 0, 1, 0);
    check("lb_pos_lit", load_data, 32'h0000007F);

    // Misaligned ops are refused with a misalign pulse
    refused_op(1'b0, F3_LH, 32'h201, 1'b0, 1'b1);
    refused_op(1'b1, F3_SW, 32'h102, 1'b0, 1'b1);
    // Flush with a valid op in IDLE: no request
    refused_op(1'b0, F3_LW, 32'h400, 1'b1, 1'b0);

    // Flush during the access: bus completes, no writeback
    run_op(1'b0, F3_LW, 32'h500, '0, 32'h12345678, 0, 2, 2);
    run_op(1'b0, F3_LH, 32'h504, '0, 32'h12345678, 1, 1, 1);

    // gnt/rvalid while idle are ignored
    @(negedge clk);
    bus.dmem_gnt = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    bus.dmem_rvalid = 1'b0;
    #1;
    check("stray_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("stray_no_lv", {31'd0, load_valid}, 32'd0);

    // Asynchronous reset in the middle of REQ
    @(negedge clk);
    mem_op = {1'b1, 1'b0, F3_LW};
    addr = 32'h600;
    exp_addr = 32'h600;
    exp_be = 4'hF;
    exp_we = 1'b0;
    exp_req_valid = 1'b1;
    @(negedge clk);
    #1;
    check("pre_rst_req", {31'd0, bus.dmem_req}, 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, bus.dmem_req}, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("mid_rst_load_data", load_data, 32'd0);
    mem_op = 5'd0;
    exp_req_valid = 1'b0;
    @(negedge clk);
    nrst = 1'b1;

`ifdef DMEM_TIMEOUT_EN
    // gnt never comes: DONE after TMO REQ cycles with a bus_err pulse
    @(negedge clk);
    mem_op = {1'b1, 1'b0, F3_LW};
    addr = 32'h700;
    exp_addr = 32'h700;
    exp_be = 4'hF;
    exp_we = 1'b0;
    exp_req_valid = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      #1;
      check("tmo_req", {31'd0, bus.dmem_req}, 32'd1);
    end
    exp_bus_err = 1'b1;
    @(negedge clk);
    #1;
    check("tmo_done", {30'd0, dbg_state}, {30'd0, ST_DONE});
    check("tmo_bus_err", {31'd0, bus_err}, 32'd1);
    check("tmo_no_lv", {31'd0, load_valid}, 32'd0);
    @(posedge clk);
    #1;
    mem_op = 5'd0;
    exp_req_valid = 1'b0;
    exp_bus_err = 1'b0;
    @(negedge clk);
    #1;
    check("tmo_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
`endif

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences the data-memory access for the instruction held in the M1 stage.
- Drives a req/gnt/rvalid data-memory bus and issues a pipeline stall that freezes the M1→M2 pipeline register and all upstream stage registers.
- Returns aligned, sign/zero-extended load data to the M2 writeback path.
- Sits between the M1 stage outputs (mem_op, ALU result as address, store data) and the data-memory port.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles waited for dmem_gnt or dmem_rvalid; used only with DMEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- mem_op  in  5  M1 memory op: [4] valid, [3] store, [2:0] funct3
- addr  in  32  byte address (M1 ALU result)
- wdata  in  32  store data, unaligned, in low bits
- flush  in  1  kill the M1 instruction (trap/redirect)
- stall  out  1  freeze M1→M2 register and upstream registers
- misalign  out  1  misaligned access detected; pulse in IDLE
- load_data  out  32  formatted load result
- load_valid  out  1  one-cycle pulse; load_data valid
- bus_err  out  1  timeout pulse (0 unless DMEM_TIMEOUT_EN)
- dmem_req  out  1  request, held until grant
- dmem_we  out  1  write enable
- dmem_addr  out  32  word-aligned address, addr[31:2] concatenated with 2'b00
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  store data shifted into byte lanes
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - All outputs and registers go to 0, including dmem_req, which drops mid-transaction.
- States: IDLE, REQ, RESP, DONE.
- IDLE, accept condition is mem_op[4] & ~flush & ~misaligned:
  - On accept: latch we/addr/be/wdata/funct3, go to REQ, stall=1 combinationally in this same cycle.
  - Otherwise stay in IDLE with stall=0.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - misalign=1 in IDLE (combinational); no request and no stall.
- REQ:
  - dmem_req=1; address, be, we and wdata are stable from registers; stall=1.
  - On gnt: a store goes to DONE; a load goes to RESP.
- RESP:
  - stall=1.
  - On rvalid: register the formatted rdata into load_data and go to DONE.
  - rvalid may arrive in the cycle after gnt at the earliest.
- DONE:
  - stall=0, so the pipeline advances at the next edge.
  - load_valid=1 for a load that was not killed.
  - Never accepts a new op; always returns to IDLE.
- Byte enables by funct3[1:0]:
  - Byte: 4'b0001 shifted left by addr[1:0].
  - Half: 4'b0011 shifted left by addr[1:0].
  - Word: 4'b1111.
- wdata lane placement: replicated by size (byte×4, half×2) so the selected lanes carry the data.
- Load format, using the byte offset addr[1:0]:
  - LB/LH: sign-extend the selected byte/half.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- Latency:
  - Store with gnt in the first REQ cycle: 3 cycles (IDLE, REQ, DONE).
  - Load with gnt and rvalid back-to-back: 4 cycles.
- Flush handling:
  - flush asserted in REQ or RESP sets a kill flag; the bus transaction still completes per protocol.
  - In DONE a killed load does not pulse load_valid.
  - flush together with a valid op in IDLE: no request is issued.
- load_data holds its value until the next load completes.
- dmem_gnt or dmem_rvalid seen outside REQ/RESP is ignored.

Optional Feature:
- DMEM_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and RESP and increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES-1 without the awaited gnt/rvalid: go to DONE, pulse bus_err for 1 cycle, and suppress load_valid.
- Undefined: the FSM waits indefinitely, no counter is generated, and bus_err is tied to 0.

Decomposition:
- Package dmem_pkg:
  - mem_op field indices (VALID=4, STORE=3, F3 range 2:0).
  - funct3 constants LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - State enum typedef.
- Sub-module dmem_load_fmt: combinational; inputs rdata, byte offset, funct3; output the formatted 32-bit load data.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt at REQ cycle 1 → dmem_be=1111, dmem_addr=0x100, stall high 2 cycles, DONE on 3rd cycle, no load_valid.
- SB addr=0x103, wdata=0x000000A5 → dmem_be=1000, dmem_wdata[31:24]=0xA5.
- LB addr=0x202, rdata=0x00800000, gnt delayed 2 cycles, rvalid 3 cycles after gnt → load_data=0xFFFFFF80, load_valid 1 pulse, stall released exactly in DONE; same case with LBU → 0x00000080.
- LH addr=0x201 → misalign=1, dmem_req never asserts, stall=0.
- LW in flight, flush in RESP → transaction completes, load_valid stays 0, FSM back in IDLE.
- nrst low while in REQ → dmem_req and stall drop immediately, state IDLE; with DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, gnt never asserted → bus_err pulse after 8 REQ cycles, then IDLE.
